rf_access_arbiter: RTL and testbench

//   Shares the single-port register file between two masters: requester 0 is
//   the UART command controller, requester 1 is the config/debug master.

---
 rtl/rf_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares the single-port register file between two masters: requester 0
//   (UART command controller) and requester 1 (config/debug master).
//   Round-robin arbitration, one RF write or read per grant. A single
//   outstanding read is tracked and its data routed back to the owner. A
//   timeout aborts the read if RF_RdData_VLD never arrives.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   REQn/WEn/ADDRn/WDATAn    request, write enable, address, write data
//   GNTn                     1-cycle pulse when the request is issued to the RF
//   RDATAn/RVLDn             read data (held) and 1-cycle valid pulse per owner
//   RF_WrEn/RF_RdEn          RF strobes
//   RF_Address/RF_WrData     RF address and write data
//   RF_RdData/RF_RdData_VLD  RF read return
//   BUSY                     high whenever the FSM is not idle
//   TIMEOUT_ERR              1-cycle pulse when a read is aborted
//
// All outputs are registered: every output flop is loaded with the value it
// must show in the state the FSM is entering.

module rf_access_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [ADDR-1:0]  ADDR0,
  input  logic [ADDR-1:0]  ADDR1,
  input  logic [WIDTH-1:0] WDATA0,
  input  logic [WIDTH-1:0] WDATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] RDATA0,
  output logic [WIDTH-1:0] RDATA1,
  output logic             RVLD0,
  output logic             RVLD1,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_RdData_VLD,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;     // index of the last granted requester
  logic             owner_q, owner_d;   // owner of the access in flight
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             rvld0_q, rvld0_d, rvld1_q, rvld1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             wren_q, wren_d, rden_q, rden_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             to_err_q, to_err_d;

  // Arbitration: on a tie the requester that was not granted last wins.
  logic             win;
  logic             win_we;
  logic [ADDR-1:0]  win_addr;
  logic [WIDTH-1:0] win_wdata;

  always_comb begin
    win = 1'b0;
    if (REQ0 && REQ1) begin
      win = ~last_q;
    end else begin
      win = REQ1;
    end
    win_we    = win ? WE1    : WE0;
    win_addr  = win ? ADDR1  : ADDR0;
    win_wdata = win ? WDATA1 : WDATA0;
  end

  // Hand the read result (or zero on abort) to the owner only; the other
  // requester's RDATA/RVLD are left untouched.
  task automatic deliver(input logic [WIDTH-1:0] data);
    if (owner_q) begin
      rdata1_d = data;
      rvld1_d  = 1'b1;
    end else begin
      rdata0_d = data;
      rvld0_d  = 1'b1;
    end
  endtask

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rvld0_d  = 1'b0;
    rvld1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    to_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = S_ISSUE;
          owner_d = win;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          wren_d  = win_we;
          rden_d  = ~win_we;
          addr_d  = win_addr;
          wdata_d = win_we ? win_wdata : '0;
        end
      end

      S_ISSUE: begin
        // wren_q still holds the strobe being shown this cycle.
        if (wren_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_WAIT;
          cnt_d   = '0;
        end
      end

      S_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Valid data takes priority over a timeout in the same cycle.
        if (RF_RdData_VLD) begin
          deliver(RF_RdData);
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          deliver('0);
          to_err_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rvld0_q  <= rvld0_d;
      rvld1_q  <= rvld1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      to_err_q <= to_err_d;
    end
  end

  assign GNT0        = gnt0_q;
  assign GNT1        = gnt1_q;
  assign RVLD0       = rvld0_q;
  assign RVLD1       = rvld1_q;
  assign RDATA0      = rdata0_q;
  assign RDATA1      = rdata1_q;
  assign RF_WrEn     = wren_q;
  assign RF_RdEn     = rden_q;
  assign RF_Address  = addr_q;
  assign RF_WrData   = wdata_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Testbench for rf_access_arbiter: directed vector table plus hand-written
// sequences for timeout, VLD/timeout collision and reset during a read.

module tb_rf_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0, REQ1, WE0, WE1;
  logic [3:0] ADDR0, ADDR1;
  logic [7:0] WDATA0, WDATA1;
  logic       GNT0, GNT1, RVLD0, RVLD1;
  logic [7:0] RDATA0, RDATA1;
  logic       RF_WrEn, RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, RF_RdData;
  logic       RF_RdData_VLD;
  logic       BUSY, TIMEOUT_ERR;

  rf_access_arbiter #(.WIDTH(8), .ADDR(4), .TIMEOUT(15), .TO_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .RVLD0(RVLD0), .RVLD1(RVLD1),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {GNT0,GNT1,WrEn,RdEn,Addr[4],WrData[8],RVLD0,RVLD1,
  //                 RDATA0[8],RDATA1[8],BUSY,TIMEOUT_ERR}
  logic [35:0] act;
  assign act = {GNT0, GNT1, RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
                RVLD0, RVLD1, RDATA0, RDATA1, BUSY, TIMEOUT_ERR};

  typedef struct {
    logic        r0, w0;
    logic [3:0]  a0;
    logic [7:0]  d0;
    logic        r1, w1;
    logic [3:0]  a1;
    logic [7:0]  d1;
    logic        vld;
    logic [7:0]  rd;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [35:0] e(input logic g0, g1, wen, ren,
                                    input logic [3:0] ra, input logic [7:0] rw,
                                    input logic v0, v1,
                                    input logic [7:0] q0, q1,
                                    input logic busy, terr);
    return {g0, g1, wen, ren, ra, rw, v0, v1, q0, q1, busy, terr};
  endfunction

  task automatic add(input logic r0, w0, input logic [3:0] a0, input logic [7:0] d0,
                     input logic r1, w1, input logic [3:0] a1, input logic [7:0] d1,
                     input logic vld, input logic [7:0] rd, input logic [35:0] ex);
    vecs[nv].r0 = r0; vecs[nv].w0 = w0; vecs[nv].a0 = a0; vecs[nv].d0 = d0;
    vecs[nv].r1 = r1; vecs[nv].w1 = w1; vecs[nv].a1 = a1; vecs[nv].d1 = d1;
    vecs[nv].vld = vld; vecs[nv].rd = rd; vecs[nv].exp = ex;
    nv++;
  endtask

  task automatic drive(input logic r0, w0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic r1, w1, input logic [3:0] a1, input logic [7:0] d1,
                       input logic vld, input logic [7:0] rd);
    REQ0 = r0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
    REQ1 = r1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
    RF_RdData_VLD = vld; RF_RdData = rd;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00);
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are sampled
  // at the same point, after the edge that registered them.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [35:0] a, input logic [35:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, x);
    end else begin
      $display("ok   %s: %h", nm, a);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int x);
    n_cmp++;
    if (a != x) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, x);
    end else begin
      $display("ok   %s: %0d", nm, a);
    end
  endtask

  initial begin
    int n;
    int seen;

    // ------------------------------------------------------------ table
    //  req0 we0 a0  d0      req1 we1 a1  d1     vld rd     expected
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'h00,0,0));
    // write by 0: A=3 D=5A, strobe next cycle, BUSY low the cycle after
    add(1,1,4'h3,8'h5A, 0,0,4'h0,8'h00, 0,8'h00, e(1,0,1,0,4'h3,8'h5A,0,0,8'h00,8'h00,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'h00,0,0));
    // read by 1: A=7, RF returns C3 one cycle after RdEn
    add(0,0,4'h0,8'h00, 1,0,4'h7,8'h00, 0,8'h00, e(0,1,0,1,4'h7,8'h00,0,0,8'h00,8'h00,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'h00,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1,8'hC3, e(0,0,0,0,4'h0,8'h00,0,1,8'h00,8'hC3,0,0));
    // both requesting back-to-back: order 0,1,0,1
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(1,0,1,0,4'h2,8'h22,0,0,8'h00,8'hC3,1,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'hC3,0,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(0,1,1,0,4'h4,8'h44,0,0,8'h00,8'hC3,1,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'hC3,0,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(1,0,1,0,4'h2,8'h22,0,0,8'h00,8'hC3,1,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'hC3,0,0));
    add(1,1,4'h2,8'h22, 1,1,4'h4,8'h44, 0,8'h00, e(0,1,1,0,4'h4,8'h44,0,0,8'h00,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'hC3,0,0));
    // read by 0; request 1 arrives while busy and waits for the next IDLE
    add(1,0,4'h5,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(1,0,0,1,4'h5,8'h00,0,0,8'h00,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 1,1,4'h9,8'h99, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 1,1,4'h9,8'h99, 1,8'hA5, e(0,0,0,0,4'h0,8'h00,1,0,8'hA5,8'hC3,0,0));
    add(0,0,4'h0,8'h00, 1,1,4'h9,8'h99, 0,8'h00, e(0,1,1,0,4'h9,8'h99,0,0,8'hA5,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, e(0,0,0,0,4'h0,8'h00,0,0,8'hA5,8'hC3,0,0));
    // stray VLD in IDLE ignored
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1,8'hFF, e(0,0,0,0,4'h0,8'h00,0,0,8'hA5,8'hC3,0,0));
    // read by 1 with a stale VLD during ISSUE, real data one cycle later
    add(0,0,4'h0,8'h00, 1,0,4'h6,8'h00, 0,8'h00, e(0,1,0,1,4'h6,8'h00,0,0,8'hA5,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1,8'hEE, e(0,0,0,0,4'h0,8'h00,0,0,8'hA5,8'hC3,1,0));
    add(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1,8'h77, e(0,0,0,0,4'h0,8'h00,0,1,8'hA5,8'h77,0,0));

    // ------------------------------------------------------------ reset
    idle_inputs();
    RST = 1'b0;
    step();
    step();
    check("reset_state", act, 36'h0);
    RST = 1'b1;

    // ------------------------------------------------------------ vectors
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1,
            vecs[i].vld, vecs[i].rd);
      step();
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // ------------------------------------------------------------ timeout
    drive(1, 0, 4'h8, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00);
    step();
    check("to_issue", act, e(1,0,0,1,4'h8,8'h00,0,0,8'hA5,8'h77,1,0));
    idle_inputs();
    step();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (RVLD0 || RVLD1) break;
    end
    check_int("to_wait_cycles", n, 15);
    check("to_abort", act, e(0,0,0,0,4'h0,8'h00,1,0,8'h00,8'h77,0,1));
    step();
    check("to_pulse_end", act, e(0,0,0,0,4'h0,8'h00,0,0,8'h00,8'h77,0,0));
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'hA, 8'hBB, 0, 8'h00);
    step();
    check("to_next_served", act, e(0,1,1,0,4'hA,8'hBB,0,0,8'h00,8'h77,1,0));
    idle_inputs();
    step();

    // --------------------------------------------- VLD on last timeout cycle
    drive(1, 0, 4'hC, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00);
    step();
    check("col_issue", act, e(1,0,0,1,4'hC,8'h00,0,0,8'h00,8'h77,1,0));
    idle_inputs();
    step();
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (RVLD0 || RVLD1 || TIMEOUT_ERR) seen++;
    end
    check_int("col_no_early_rvld", seen, 0);
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 8'h3C);
    step();
    check("col_vld_wins", act, e(0,0,0,0,4'h0,8'h00,1,0,8'h3C,8'h77,0,0));
    idle_inputs();
    step();

    // --------------------------------------------- reset during RD_WAIT
    drive(1, 0, 4'hD, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00);
    step();
    check("rst_issue", act, e(1,0,0,1,4'hD,8'h00,0,0,8'h3C,8'h77,1,0));
    idle_inputs();
    step();
    step();
    RST = 1'b0;
    #1;
    check("rst_async_clear", act, 36'h0);
    step();
    RST = 1'b1;
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 8'h99);
    step();
    check("rst_late_vld", act, 36'h0);
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'hE, 8'hE1, 0, 8'h00);
    step();
    check("rst_req1_served", act, e(0,1,1,0,4'hE,8'hE1,0,0,8'h00,8'h00,1,0));
    idle_inputs();
    step();
    check("rst_final_idle", act, 36'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
